cga_scandoubler: RTL
====================

CGA_SCANDOUBLER -- requirements
Module: cga_scandoubler

Interface
REQ-001 SHALL have parameter LINE_MAX, default 1024, giving the maximum stored input pixels per line.
REQ-002 SHALL have parameter DBL_HSYNC_W, default 54, giving the output hsync pulse width in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: single clock, 28.636 MHz; every register is on its rising edge.
REQ-004 SHALL have port busreset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_ce, input, 1 bit: input pixel strobe, nominally high one clk in two.
REQ-006 SHALL have port video, input, 4 bits: RGBI pixel from the CGA core, sampled when in_ce=1.
REQ-007 SHALL have port hsync, input, 1 bit: input horizontal sync, sampled when in_ce=1.
REQ-008 SHALL have port vsync, input, 1 bit: input vertical sync, sampled when in_ce=1.
REQ-009 SHALL have port dbl_video, output, 4 bits: line-doubled RGBI pixel, one per clk.
REQ-010 SHALL have port dbl_hsync, output, 1 bit: doubled-rate horizontal sync, active high.
REQ-011 SHALL have port dbl_vsync, output, 1 bit: vsync aligned to the output lines.

Function
REQ-012 SHALL start an input line on an in_ce-qualified rising edge of hsync; the write column wr_x resets to 0 and the write buffer toggles (ping-pong, 2 x LINE_MAX x 4 bits).
REQ-013 SHALL write video at wr_x on each in_ce, then increment wr_x; wr_x saturates at LINE_MAX-1 and writes at saturation are dropped.
REQ-014 SHALL latch line_len = wr_x (the saturated count of in_ce strobes) at each hsync rising edge.
REQ-015 SHALL run a reader FSM with states IDLE, COPY0, COPY1: IDLE->COPY0 on the first line start after reset; COPY0->COPY1 when rd_x reaches line_len-1; COPY1->COPY0 on the next line start.
REQ-016 SHALL, when COPY1 completes with no new line start, hold COPY1 outputting 4'h0 until the next line start.
REQ-017 SHALL make a line start preempt COPY0 or COPY1 at any rd_x: the state goes to COPY0, rd_x goes to 0, and the reader switches to the just-completed buffer.
REQ-018 SHALL advance rd_x by 1 every clk in COPY0/COPY1 and read the buffer not being written.
REQ-019 SHALL have the read path take 2 clks (sync RAM plus output register) from rd_x to dbl_video; dbl_hsync and dbl_vsync are delayed to match.
REQ-020 SHALL, for line_len=0 or in IDLE, drive dbl_video=0 and dbl_hsync=0.
REQ-021 SHALL assert dbl_hsync for DBL_HSYNC_W clks starting at rd_x=0 of each copy; the pulse is truncated if the next copy starts earlier.
REQ-022 SHALL make dbl_vsync equal the in_ce-sampled vsync, re-registered at each COPY0 start (so it changes only on output line boundaries).
REQ-023 SHALL, when a line start and an in_ce write occur in the same clk, write the pixel at column 0 of the new buffer.

Reset
REQ-024 SHALL, while busreset=1, force state=IDLE, wr_x=rd_x=0, line_len=0, dbl_video=0, dbl_hsync=0, dbl_vsync=0, with buffer select=0; RAM contents are not cleared.
REQ-025 SHALL, on reset mid-line, discard the partial line; output resumes at the second subsequent hsync rising edge.

Configuration
REQ-026 SHALL, with macro CGA_SCANLINES_EN defined, add input port scanlines (1 bit), and drive dbl_video=4'h0 during COPY1 while scanlines=1.
REQ-027 SHALL, with CGA_SCANLINES_EN undefined, omit the scanlines port and make COPY1 output identical to COPY0.

Structure
REQ-028 SHALL place LINE_MAX, the RGBI width (4) and the reader state encoding in shared package cga_pkg.
REQ-029 SHALL implement the ping-pong storage as sub-module cga_linebuf: 1 write port, 1 registered read port, bank select bit, 1-clk read latency.

Verification
REQ-030 SHALL cover steady state: in_ce every 2nd clk, 456-pixel lines, video=column mod 16 -> each line output twice, 456 clks per copy, dbl_video[n]=n mod 16, delayed 1 input line + 2 clks.
REQ-031 SHALL cover hsync width: DBL_HSYNC_W=54 -> dbl_hsync high exactly 54 clks at each copy start, period 456 clks.
REQ-032 SHALL cover overflow: a 1500-pixel line -> line_len=1023, pixels 0..1022 replayed, no wrap corruption of the other buffer.
REQ-033 SHALL cover preemption: a line shortened to 300 pixels after 456-pixel lines -> COPY1 cut at the new line start, COPY0 restarts at rd_x=0.
REQ-034 SHALL cover mid-line reset: busreset pulsed 1 clk at pixel 200 -> outputs 0 next clk, IDLE until hsync, valid output after the second hsync.
REQ-035 SHALL cover scanlines (CGA_SCANLINES_EN, scanlines=1): video=4'hF -> COPY0 outputs F, COPY1 outputs 0.

Source files
------------

// File: rtl/cga_pkg.sv
// cga_pkg: shared constants and reader state encoding
// for the CGA scandoubler (line length, RGBI width, states).
package cga_pkg;

  localparam int LINE_MAX = 1024;
  localparam int RGBI_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY0 = 2'd1,
    ST_COPY1 = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cga_linebuf.sv
// cga_linebuf: ping-pong line store, 2 banks x DEPTH x RGBI.
// Ports: clk; write we/wr_bank/wr_addr/wr_data; read rd_bank/rd_addr -> rd_data (1 clk).
module cga_linebuf
  import cga_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [RGBI_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [RGBI_W-1:0] rd_data
);

  logic [RGBI_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/cga_scandoubler.sv
// cga_scandoubler: stores CGA lines at in_ce rate, replays each twice at clk rate.
// Ports: clk, busreset, in_ce, video, hsync, vsync [, scanlines with CGA_SCANLINES_EN] -> dbl_video/hsync/vsync.
module cga_scandoubler #(
  parameter int LINE_MAX    = cga_pkg::LINE_MAX,
  parameter int DBL_HSYNC_W = 54
) (
  input  logic                      clk,
  input  logic                      busreset,
  input  logic                      in_ce,
  input  logic [cga_pkg::RGBI_W-1:0] video,
  input  logic                      hsync,
  input  logic                      vsync,
`ifdef CGA_SCANLINES_EN
  input  logic                      scanlines,
`endif
  output logic [cga_pkg::RGBI_W-1:0] dbl_video,
  output logic                      dbl_hsync,
  output logic                      dbl_vsync
);

  import cga_pkg::*;

  localparam int AW = $clog2(LINE_MAX);
  localparam logic [AW-1:0] X_MAX = AW'(LINE_MAX - 1);

  logic              hsync_q;
  logic              vsync_q;
  logic              line_start;
  logic              buf_sel;
  logic              line_valid;
  logic [AW-1:0]     wr_x;
  logic [AW-1:0]     line_len;
  logic              we;
  logic              wr_bank;
  logic [AW-1:0]     wr_addr;
  logic [RGBI_W-1:0] rd_data;

  rd_state_t         state, state_n;
  logic [AW-1:0]     rd_x, rd_x_n;
  logic              done, done_n;
  logic              last;
  logic              active;
  logic              vid_en;
  logic              hs_raw;
  logic              vs_line;
  logic              vid_en_d;
  logic              hs_d;
  logic              vs_d;

  assign line_start = in_ce & hsync & ~hsync_q;

  // The pixel arriving with the line start lands at column 0 of the new bank.
  assign wr_bank = line_start ? ~buf_sel : buf_sel;
  assign wr_addr = line_start ? '0 : wr_x;
  assign we      = in_ce & ~busreset & (line_start | (wr_x != X_MAX));

  // line_valid keeps a line cut by reset from ever being replayed.
  always_ff @(posedge clk) begin
    if (busreset) begin
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      buf_sel    <= 1'b0;
      line_valid <= 1'b0;
      wr_x       <= '0;
      line_len   <= '0;
    end else if (in_ce) begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (line_start) begin
        buf_sel    <= ~buf_sel;
        wr_x       <= AW'(1);
        line_len   <= line_valid ? wr_x : '0;
        line_valid <= 1'b1;
      end else if (wr_x != X_MAX) begin
        wr_x <= wr_x + 1'b1;
      end
    end
  end

  cga_linebuf #(
    .DEPTH (LINE_MAX),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .we      (we),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (video),
    .rd_bank (~buf_sel),
    .rd_addr (rd_x),
    .rd_data (rd_data)
  );

  assign last = (line_len == '0) || (rd_x == line_len - 1'b1);

  always_comb begin
    state_n = state;
    rd_x_n  = rd_x;
    done_n  = done;
    if (line_start) begin
      state_n = ST_COPY0;
      rd_x_n  = '0;
      done_n  = 1'b0;
    end else begin
      case (state)
        ST_COPY0: begin
          if (last) begin
            state_n = ST_COPY1;
            rd_x_n  = '0;
          end else begin
            rd_x_n = rd_x + 1'b1;
          end
        end
        ST_COPY1: begin
          if (last) done_n = 1'b1;
          else      rd_x_n = rd_x + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign active = (state != ST_IDLE) && (line_len != '0) && !done;
  assign hs_raw = active && (int'(rd_x) < DBL_HSYNC_W);

`ifdef CGA_SCANLINES_EN
  assign vid_en = active && !((state == ST_COPY1) && scanlines);
`else
  assign vid_en = active;
`endif

  always_ff @(posedge clk) begin
    if (busreset) begin
      state     <= ST_IDLE;
      rd_x      <= '0;
      done      <= 1'b0;
      vs_line   <= 1'b0;
      vid_en_d  <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      dbl_video <= '0;
      dbl_hsync <= 1'b0;
      dbl_vsync <= 1'b0;
    end else begin
      state     <= state_n;
      rd_x      <= rd_x_n;
      done      <= done_n;
      if (line_start) vs_line <= vsync_q;
      vid_en_d  <= vid_en;
      hs_d      <= hs_raw;
      vs_d      <= vs_line;
      dbl_video <= vid_en_d ? rd_data : '0;
      dbl_hsync <= hs_d;
      dbl_vsync <= vs_d;
    end
  end

endmodule
